alu_pipe: RTL and testbench

Parametrised, pipelined signed ALU; successor to the two-op add/multiply ALU. Supports add, subtract, multiply and multiply-accumulate (MAC), with a per-operation wrap/saturate mode. Uses valid/ready handshakes on both sides and has a fixed in-order latency. Sits between an operand source (sequencer/FIFO) and a result sink that may apply backpressure.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_pipe_mult.sv | 31 +++
 rtl/alu_pipe.sv | 146 ++++++++++++++
 tb/tb_alu_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the pipelined signed ALU.
// Holds the op encoding, the per-beat control bundle and the flag function.
package alu_pkg;

  // Wide enough for full-precision results of N up to 64
  localparam int TW = 130;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_MUL = 2'd1,
    OP_SUB = 2'd2,
    OP_MAC = 2'd3
  } op_e;

  typedef struct packed {
    op_e  op;
    logic sat_en;
  } beat_ctl_t;

  typedef struct packed {
    logic ov;
    logic uv;
  } flags_t;

  // Overflow/underflow of a full-precision value against an n-bit range
  function automatic flags_t sat_flags(
    input logic signed [TW-1:0] t,
    input int                   n
  );
    logic signed [TW-1:0] lim;
    flags_t f;
    lim  = TW'(1) <<< (n - 1);
    f.ov = t > (lim - TW'(1));
    f.uv = t < -lim;
    return f;
  endfunction

endpackage

// File: rtl/alu_pipe_mult.sv
// pipe_mult: signed N x N -> 2N multiplier.
// STAGES registers deep, all sharing one advance enable.
module pipe_mult #(
  parameter int N      = 16,
  parameter int STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic signed [N-1:0]   i_a,
  input  logic signed [N-1:0]   i_b,
  output logic signed [2*N-1:0] o_p
);

  localparam int P = 2 * N;

  logic signed [P-1:0] r_p [STAGES];

  // Product in the first stage, then pure delay registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) r_p[i] <= '0;
    end else if (i_en) begin
      r_p[0] <= P'(i_a) * P'(i_b);
      for (int i = 1; i < STAGES; i++) r_p[i] <= r_p[i-1];
    end
  end

  assign o_p = r_p[STAGES-1];

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined signed ADD/SUB/MUL/MAC with wrap or saturate.
// Fixed latency MUL_STAGES+1; whole pipe freezes on output backpressure.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int N          = 16,
  parameter int MUL_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          op,
  input  logic                sat_en,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic                acc_clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] result,
  output logic                ov,
  output logic                uv,
  output logic [1:0]          out_op
);

  localparam int S = MUL_STAGES;
  localparam int P = 2 * N;

  logic                w_stall;
  logic                w_en;
  logic [S-1:0]        r_v;
  beat_ctl_t           r_c [S];
  logic signed [N-1:0] r_a [S];
  logic signed [N-1:0] r_b [S];
  logic signed [P-1:0] w_p;

  beat_ctl_t            w_c;
  logic signed [N-1:0]  w_acc_src;
  logic signed [TW-1:0] w_true;
  flags_t               w_fl;
  logic signed [N-1:0]  w_res;

  logic                r_out_valid;
  logic signed [N-1:0] r_res;
  logic                r_ov;
  logic                r_uv;
  op_e                 r_op;
  logic signed [N-1:0] r_acc;

  assign w_stall  = r_out_valid & ~out_ready;
  assign w_en     = ~w_stall;
  assign in_ready = w_en;

  pipe_mult #(
    .N      (N),
    .STAGES (S)
  ) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_en),
    .i_a   (a),
    .i_b   (b),
    .o_p   (w_p)
  );

  // Control and add/sub operands ride alongside the multiplier stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int i = 0; i < S; i++) begin
        r_c[i] <= '0;
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else if (w_en) begin
      r_v[0] <= in_valid;
      r_c[0] <= '{op: op_e'(op), sat_en: sat_en};
      r_a[0] <= a;
      r_b[0] <= b;
      for (int i = 1; i < S; i++) begin
        r_v[i] <= r_v[i-1];
        r_c[i] <= r_c[i-1];
        r_a[i] <= r_a[i-1];
        r_b[i] <= r_b[i-1];
      end
    end
  end

  assign w_c       = r_c[S-1];
  assign w_acc_src = acc_clr ? '0 : r_acc;

  // Last stage: full-precision result, flags, then wrap or clamp
  always_comb begin
    w_true = '0;
    unique case (w_c.op)
      OP_ADD: w_true = TW'(r_a[S-1]) + TW'(r_b[S-1]);
      OP_SUB: w_true = TW'(r_a[S-1]) - TW'(r_b[S-1]);
      OP_MUL: w_true = TW'(w_p);
      OP_MAC: w_true = TW'(w_acc_src) + TW'(w_p);
    endcase
    w_fl  = sat_flags(w_true, N);
    w_res = w_true[N-1:0];
    if (w_c.sat_en & w_fl.ov) begin
      w_res = {1'b0, {(N-1){1'b1}}};
    end else if (w_c.sat_en & w_fl.uv) begin
      w_res = {1'b1, {(N-1){1'b0}}};
    end
  end

  // Output register; held while the sink stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_ov        <= 1'b0;
      r_uv        <= 1'b0;
      r_op        <= OP_ADD;
    end else if (w_en) begin
      r_out_valid <= r_v[S-1];
      if (r_v[S-1]) begin
        r_res <= w_res;
        r_ov  <= w_fl.ov;
        r_uv  <= w_fl.uv;
        r_op  <= w_c.op;
      end
    end
  end

  // Accumulator takes each retiring MAC result; clear works even in stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_en & r_v[S-1] & (w_c.op == OP_MAC)) begin
      r_acc <= w_res;
    end else if (acc_clr) begin
      r_acc <= '0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_res;
  assign ov        = r_ov;
  assign uv        = r_uv;
  assign out_op    = r_op;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe.
// Driver pushes expected beats; a monitor pops and compares on transfer.
module tb_alu_pipe;

  localparam int N = 16;
  localparam int S = 2;
  localparam int L = S + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic        sat_en;
  logic signed [N-1:0] a;
  logic signed [N-1:0] b;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic signed [N-1:0] result;
  logic        ov;
  logic        uv;
  logic [1:0]  out_op;

  always #5 clk = ~clk;

  alu_pipe #(
    .N          (N),
    .MUL_STAGES (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .sat_en    (sat_en),
    .a         (a),
    .b         (b),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ov        (ov),
    .uv        (uv),
    .out_op    (out_op)
  );

  typedef struct {
    logic [15:0] r;
    logic        ov;
    logic        uv;
    logic [1:0]  op;
    int          t;
    bit          lat;
  } exp_t;

  exp_t   q[$];
  int     n_chk = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     n_seen = 0;
  longint m_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor: handshake, hold stability, scoreboard pop
  initial begin : mon
    exp_t        e;
    logic        hv;
    logic [19:0] h;
    hv = 1'b0;
    h  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hv = 1'b0;
      end else begin
        if (out_valid) n_seen++;
        chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
        if (hv && out_valid)
          chk("hold", 32'({result, ov, uv, out_op}), 32'(h));
        hv = out_valid && !out_ready;
        h  = {result, ov, uv, out_op};
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_out: got %0h expected none", result);
          end else begin
            e = q.pop_front();
            chk("result", 32'({result, ov, uv, out_op}),
                32'({e.r, e.ov, e.uv, e.op}));
            if (e.lat) chk("latency", 32'(cyc - e.t), 32'(L));
          end
        end
      end
    end
  end

  task automatic send(input logic [1:0] o, input logic s,
                      input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] er, input logic eo,
                      input logic eu, input bit lat);
    exp_t e;
    bit   ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    op       = o;
    sat_en   = s;
    a        = x;
    b        = y;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e.r   = er;
        e.ov  = eo;
        e.uv  = eu;
        e.op  = o;
        e.t   = cyc;
        e.lat = lat;
        q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  task automatic pulse_clr();
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
  endtask

  task automatic model(input logic [1:0] o, input logic s,
                       input logic signed [15:0] x,
                       input logic signed [15:0] y,
                       output logic [15:0] r,
                       output logic fo, output logic fu);
    longint t;
    case (o)
      2'd0:    t = longint'(x) + longint'(y);
      2'd1:    t = longint'(x) * longint'(y);
      2'd2:    t = longint'(x) - longint'(y);
      default: t = m_acc + longint'(x) * longint'(y);
    endcase
    fo = t > 32767;
    fu = t < -32768;
    r  = t[15:0];
    if (s && fo) r = 16'h7FFF;
    else if (s && fu) r = 16'h8000;
    if (o == 2'd3) m_acc = longint'($signed(r));
  endtask

  initial begin : drv
    int seen0;
    in_valid  = 1'b0;
    op        = 2'd0;
    sat_en    = 1'b0;
    a         = '0;
    b         = '0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({ov, uv}), 32'd0);
    chk("rst_out_op", 32'(out_op), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // op, sat, a, b, result, ov, uv, latency-check
    send(2'd0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b1);
    send(2'd0, 1'b1, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b1);
    send(2'd2, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1);
    send(2'd2, 1'b1, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1);
    send(2'd1, 1'b0, -16'sd300, 16'sd200, 16'h15A0, 1'b0, 1'b1, 1'b1);
    send(2'd1, 1'b1, -16'sd300, 16'sd200, 16'h8000, 1'b0, 1'b1, 1'b1);
    send(2'd1, 1'b0, 16'sd100, -16'sd3, 16'hFED4, 1'b0, 1'b0, 1'b1);
    drain();

    pulse_clr();
    send(2'd3, 1'b0, 16'd3, 16'd4, 16'd12, 1'b0, 1'b0, 1'b1);
    send(2'd3, 1'b0, 16'd5, 16'd6, 16'd42, 1'b0, 1'b0, 1'b1);
    drain();
    send(2'd3, 1'b0, 16'd2, 16'd2, 16'd4, 1'b0, 1'b0, 1'b1);
    repeat (S - 1) @(posedge clk);
    #1;
    pulse_clr();
    send(2'd3, 1'b0, 16'd1, 16'd1, 16'd5, 1'b0, 1'b0, 1'b1);
    drain();

    pulse_clr();
    m_acc = 0;
    fork
      begin
        logic [1:0]  ro;
        logic        rs;
        logic [15:0] rx;
        logic [15:0] ry;
        logic [15:0] rr;
        logic        fo;
        logic        fu;
        for (int i = 0; i < 20; i++) begin
          ro = 2'($urandom_range(0, 3));
          rs = 1'($urandom_range(0, 1));
          rx = 16'($urandom);
          ry = 16'($urandom);
          model(ro, rs, rx, ry, rr, fo, fu);
          send(ro, rs, rx, ry, rr, fo, fu, 1'b0);
        end
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    pulse_clr();
    send(2'd3, 1'b0, 16'd7, 16'd1, 16'd7, 1'b0, 1'b0, 1'b1);
    drain();
    out_ready = 1'b0;
    send(2'd2, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    send(2'd0, 1'b0, 16'd1, 16'd1, 16'd2, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_result", 32'(result), 32'd0);
    chk("async_rst_flags", 32'({ov, uv, out_op}), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen0     = n_seen;
    repeat (10) @(posedge clk);
    #1;
    chk("no_out_after_rst", 32'(n_seen), 32'(seen0));
    send(2'd3, 1'b0, 16'd1, 16'd1, 16'd1, 1'b0, 1'b0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
